// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type and sizing helper for the multi-write register file
package regfile_pkg;
  typedef enum logic {e_rf_init, e_rf_ready} rf_state_e;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_init_fsm.sv
// regfile_init_fsm: INIT/READY sequencer that sweeps zeros through every entry
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int els_p = 32,
  parameter bit init_on_reset_p = 1'b1,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  output logic                     ready_o,
  output logic                     init_v_o,
  output logic [addr_width_lp-1:0] init_addr_o
);
  localparam logic [addr_width_lp-1:0] last = addr_width_lp'(els_p - 1);
  rf_state_e state;
  logic [addr_width_lp-1:0] cnt;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state   <= init_on_reset_p ? e_rf_init : e_rf_ready;
      ready_o <= !init_on_reset_p;
      cnt     <= '0;
    end else if (state == e_rf_init) begin
      cnt <= (cnt == last) ? '0 : cnt + 1'b1;
      if (cnt == last) begin
        state   <= e_rf_ready;
        ready_o <= 1'b1;
      end
    end else if (clear_i) begin
      state   <= e_rf_init;
      ready_o <= 1'b0;
      cnt     <= '0;
    end
  assign init_v_o    = (state == e_rf_init);
  assign init_addr_o = cnt;
endmodule

// File: rtl/regfile_mw_init.sv
// regfile_mw_init: multi-write, registered-read register file with bypass and a zeroing init sweep
module regfile_mw_init
  import regfile_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 32,
  parameter int num_rs_p = 2,
  parameter int num_ws_p = 2,
  parameter bit x0_tied_to_zero_p = 1'b1,
  parameter bit bypass_p = 1'b1,
  parameter bit init_on_reset_p = 1'b1,
  localparam int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    clear_i,
  input  logic [num_ws_p-1:0]                     w_v_i,
  input  logic [num_ws_p-1:0][addr_width_lp-1:0]  w_addr_i,
  input  logic [num_ws_p-1:0][width_p-1:0]        w_data_i,
  input  logic [num_rs_p-1:0]                     r_v_i,
  input  logic [num_rs_p-1:0][addr_width_lp-1:0]  r_addr_i,
  output logic [num_rs_p-1:0][width_p-1:0]        r_data_o,
  output logic                                    ready_o,
  output logic                                    w_conflict_o
);
  logic ready, init_v, conflict;
  logic [addr_width_lp-1:0] init_addr;
  logic [num_ws_p-1:0] wv, wok;
  logic [num_ws_p-1:0][addr_width_lp-1:0] wa;
  logic [num_ws_p-1:0][width_p-1:0] wd;
  logic [num_rs_p-1:0][width_p-1:0] rd;
  logic [width_p-1:0] mem [els_p];
  regfile_init_fsm #(
    .els_p(els_p),
    .init_on_reset_p(init_on_reset_p)
  ) fsm (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .clear_i(clear_i),
    .ready_o(ready),
    .init_v_o(init_v),
    .init_addr_o(init_addr)
  );
  assign ready_o = ready;
  function automatic logic addr_ok(input logic [addr_width_lp-1:0] a);
    return (32'(a) < els_p) && !(x0_tied_to_zero_p && a == '0);
  endfunction
  // The sweep borrows write port 0; all user traffic is gated off until ready.
  always_comb begin
    wv = ready ? w_v_i : '0;
    wa = w_addr_i;
    wd = w_data_i;
    if (!ready) begin
      wv[0] = init_v;
      wa[0] = init_addr;
      wd[0] = '0;
    end
    wok = '0;
    for (int j = 0; j < num_ws_p; j++) wok[j] = wv[j] && addr_ok(wa[j]);
    conflict = 1'b0;
    for (int j = 0; j < num_ws_p; j++)
      for (int k = j + 1; k < num_ws_p; k++)
        if (wv[j] && wv[k] && wa[j] == wa[k]) conflict = 1'b1;
    for (int i = 0; i < num_rs_p; i++) begin
      rd[i] = addr_ok(r_addr_i[i]) ? mem[r_addr_i[i]] : '0;
      if (bypass_p)
        for (int j = 0; j < num_ws_p; j++)
          if (wok[j] && wa[j] == r_addr_i[i]) rd[i] = wd[j];
    end
  end
  // Later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk_i)
    for (int j = 0; j < num_ws_p; j++)
      if (wok[j]) mem[wa[j]] <= wd[j];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_data_o     <= '0;
      w_conflict_o <= 1'b0;
    end else begin
      w_conflict_o <= conflict;
      for (int i = 0; i < num_rs_p; i++)
        if (ready && r_v_i[i]) r_data_o[i] <= rd[i];
    end
endmodule
